// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character stream to 50x30 video memory writer
// Cursor tracking, control codes, and autonomous line/screen blanking.
module text_console_writer #(
    parameter int          COLS   = 50,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 11,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              CLK_CPU,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              busy,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              video_write_enable,
    output logic [7:0]        video_write_data,
    output logic [ADDR_W-1:0] video_write_addr
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CLR_SCREEN = 2'd1;
    localparam logic [1:0] CLR_LINE   = 2'd2;

    localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [5:0]        COL_LAST    = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST    = 5'(ROWS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              we_q, we_d;
    logic [7:0]        wd_q, wd_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic              row_adv;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        line_base_d = line_base_q;
        col_d       = col_q;
        row_d       = row_q;
        we_d        = 1'b0;
        wd_d        = wd_q;
        wa_d        = wa_q;
        row_adv     = 1'b0;

        case (state_q)
            CLR_SCREEN: begin
                we_d = 1'b1;
                wd_d = BLANK;
                wa_d = idx_q;
                if (idx_q == SCREEN_LAST) begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    col_d       = '0;
                    row_d       = '0;
                    line_base_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CLR_LINE: begin
                we_d = 1'b1;
                wd_d = BLANK;
                wa_d = line_base_q + idx_q;
                if (idx_q == LINE_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            IDLE: begin
                // A clear request leaves the pending byte untouched for later
                if (clear_req) begin
                    state_d = CLR_SCREEN;
                    idx_d   = '0;
                end else if (char_valid) begin
                    case (char_data)
                        8'h0A: begin
                            col_d   = '0;
                            row_adv = 1'b1;
                        end
                        8'h0D: col_d = '0;
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d = col_q - 1'b1;
                                we_d  = 1'b1;
                                wd_d  = BLANK;
                                wa_d  = line_base_q + ADDR_W'(col_q - 1'b1);
                            end
                        end
                        8'h0C: begin
                            state_d = CLR_SCREEN;
                            idx_d   = '0;
                        end
                        default: begin
                            we_d = 1'b1;
                            wd_d = char_data;
                            wa_d = line_base_q + ADDR_W'(col_q);
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                row_adv = 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase
                end
                if (row_adv) begin
                    if (row_q == ROW_LAST) begin
                        row_d       = '0;
                        line_base_d = '0;
                    end else begin
                        row_d       = row_q + 1'b1;
                        line_base_d = line_base_q + COLS_A;
                    end
                    state_d = CLR_LINE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLR_SCREEN;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_CPU or negedge reset) begin
        if (!reset) begin
            state_q     <= CLR_SCREEN;
            idx_q       <= '0;
            line_base_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            we_q        <= 1'b0;
            wd_q        <= '0;
            wa_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_base_q <= line_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
            we_q        <= we_d;
            wd_q        <= wd_d;
            wa_q        <= wa_d;
        end
    end

    assign char_ready         = (state_q == IDLE) && !clear_req;
    assign busy               = (state_q == CLR_SCREEN);
    assign cursor_col         = col_q;
    assign cursor_row         = row_q;
    assign video_write_enable = we_q;
    assign video_write_data   = wd_q;
    assign video_write_addr   = wa_q;

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- CPU-side writer for the 50x30 character video memory; it produces the write port that the display engine's RAM1536x8 consumes.
- Accepts a stream of ASCII bytes over a valid/ready handshake.
- Tracks a cursor, interprets control codes, and emits one video memory write per cycle.
- Blanks new lines and the whole screen autonomously, with no read-back from video memory.

Parameters:
- COLS, 50, characters per text row.
- ROWS, 30, text rows; COLS*ROWS must be <= 2^ADDR_W.
- ADDR_W, 11, video memory address width.
- BLANK, 8'h20, byte written when clearing.

Ports:
- CLK_CPU  in  1  CPU clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- char_valid  in  1  char_data holds a byte to consume.
- char_data  in  8  ASCII byte or control code.
- char_ready  out  1  block can accept a byte this cycle.
- clear_req  in  1  single-cycle request to clear the screen.
- busy  out  1  a clear sequence is in progress.
- cursor_col  out  6  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- video_write_enable  out  1  write strobe to video memory.
- video_write_data  out  8  byte to write.
- video_write_addr  out  ADDR_W  write address, computed as row*COLS+col.

Behaviour:
- Reset (reset=0), asynchronous:
  - Outputs: video_write_enable=0, video_write_data=0, video_write_addr=0, cursor 0/0, char_ready=0, busy=1.
  - State goes to CLR_SCREEN, clear index = 0.
  - Reset mid-operation aborts any sequence; the screen clear restarts after release.
- Write timing:
  - video_write_* are registered. A write issued in cycle k appears on the outputs in cycle k+1.
  - video_write_enable is high for exactly one cycle per write.
- Address generation:
  - line_base register holds row*COLS. It adds COLS on row advance and resets to 0 on wrap. No multiplier is used.
  - Address = line_base + col.
- States:
  - IDLE:
    - char_ready=1, busy=0.
    - clear_req=1 has priority over char_valid: go to CLR_SCREEN; the byte is not consumed.
    - Otherwise, if char_valid=1, the byte is consumed this cycle.
  - CLR_SCREEN:
    - Issues BLANK at addresses 0..COLS*ROWS-1, one per cycle (1500 cycles).
    - Then cursor = 0/0, line_base = 0, go to IDLE.
    - char_ready=0, busy=1. clear_req is ignored.
  - CLR_LINE:
    - Issues BLANK at line_base+0..line_base+COLS-1, one per cycle (50 cycles), then go to IDLE.
    - char_ready=0, busy=0.
- Byte handling in IDLE:
  - Printable (any value not listed below):
    - Issue a write at the cursor.
    - If col < COLS-1: col+1.
    - Else: col=0, then row advance.
  - 8'h0A LF: col=0, then row advance. No write.
  - 8'h0D CR: col=0. No write. Row unchanged.
  - 8'h08 BS:
    - If col > 0: col-1 and issue BLANK at the new position.
    - At col 0: no-op. No write and no row change.
  - 8'h0C FF: go to CLR_SCREEN, identical to clear_req.
- Row advance:
  - row = row+1, or 0 if row = ROWS-1 (wrap; line_base = 0).
  - Then enter CLR_LINE for the new row in the next cycle.
- Cursor outputs update in the cycle after the byte is consumed.
- Example latency (printable byte accepted at cycle N in col 49):
  - Char write visible at N+1.
  - Line-clear writes visible N+2..N+51.
  - char_ready=1 again at N+51.

Test Plan:
- Release reset, hold char_valid=0 -> 1500 writes of 8'h20 at addr 0..1499 on consecutive cycles; then busy=0, char_ready=1, cursor 0/0.
- After clear, send 'A','B' (8'h41, 8'h42) back-to-back -> writes (0,41),(1,42) on consecutive cycles; cursor_col=2, char_ready stays 1.
- Send 8'h0A at cursor row 0 col 2 -> no char write; 50 writes of 8'h20 at addr 50..99; char_ready low for 50 cycles; cursor 0/1.
- Put cursor at row 29 col 49, send 'Z' -> write (1499,5A); wrap to row 0; BLANK writes at 0..49; cursor 0/0.
- BS at col 3 row 2 -> BLANK write at addr 102, cursor_col=2. BS at col 0 -> no write, cursor unchanged.
- Assert clear_req and char_valid together in IDLE -> clear wins, byte held (char_ready=0). Pull reset low mid-clear at index 700 -> outputs zero at once; after release the clear restarts at addr 0.
